// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared word size and loop FSM state encoding for the matmul datapath
package matmul_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } loop_state_t;

endpackage

// File: rtl/loop_counter_with_decre_and_rst.sv
// rtl/loop_counter_with_decre_and_rst.sv - loadable loop down-counter with tc pulse and misuse flag
// Optional feature: define LOOP_CTR_AUTORELOAD_EN to restart from the loaded bound after each terminal step.
module loop_counter_with_decre_and_rst
  import matmul_pkg::*;
#(
  parameter int word_size = WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] data_in,
  input  logic                 write_en,
  input  logic                 decre,
  output logic [word_size-1:0] data_out,
  output logic                 zero,
  output logic                 busy,
  output logic                 tc,
  output logic                 err
);

  logic [word_size-1:0] count;
  loop_state_t          state;

`ifdef LOOP_CTR_AUTORELOAD_EN
  // Reload copy of the last loaded bound; only consumed when auto-reload is built in.
  logic [word_size-1:0] reload_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_val <= '0;
    end else if (write_en) begin
      reload_val <= data_in;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      state <= IDLE;
      tc    <= 1'b0;
      err   <= 1'b0;
    end else if (write_en) begin
      // A load always wins; a coincident decre is dropped.
      count <= data_in;
      err   <= 1'b0;
      tc    <= 1'b0;
      state <= (data_in != '0) ? COUNT : DONE;
    end else if (decre) begin
      if (state == COUNT) begin
        if (count > word_size'(1)) begin
          count <= count - word_size'(1);
          tc    <= 1'b0;
        end else begin
          tc <= 1'b1;
`ifdef LOOP_CTR_AUTORELOAD_EN
          count <= reload_val;
          state <= COUNT;
`else
          count <= '0;
          state <= DONE;
`endif
        end
      end else begin
        // Decrementing outside an active loop is a controller bug: hold count, flag it.
        err <= 1'b1;
        tc  <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
    end
  end

  assign data_out = count;
  assign zero     = (count == '0);
  assign busy     = (state == COUNT);

endmodule

// File: tb/tb_loop_counter_with_decre_and_rst.sv
// tb/tb_loop_counter_with_decre_and_rst.sv - randomized bench with behavioural loop model
module tb_loop_counter_with_decre_and_rst;
  import matmul_pkg::*;

  localparam int W = WORD_SIZE;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         write_en;
  logic         decre;
  logic [W-1:0] data_out;
  logic         zero;
  logic         busy;
  logic         tc;
  logic         err;

  int total = 0;
  int bad   = 0;
  string phase = "init";

  // Behavioural model: remaining iterations, loaded bound, loop-active flag.
  int m_remaining;
  int m_bound;
  bit m_active;
  bit m_tc;
  bit m_err;

  loop_counter_with_decre_and_rst #(.word_size(W)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .write_en(write_en),
    .decre(decre),
    .data_out(data_out),
    .zero(zero),
    .busy(busy),
    .tc(tc),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s:%s got=%0h exp=%0h", phase, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_remaining = 0;
    m_bound     = 0;
    m_active    = 0;
    m_tc        = 0;
    m_err       = 0;
  endtask

  task automatic model_step(input bit we, input int d, input bit dec);
    if (we) begin
      m_remaining = d;
      m_bound     = d;
      m_active    = (d != 0);
      m_err       = 0;
      m_tc        = 0;
    end else if (dec) begin
      if (!m_active) begin
        m_err = 1;
        m_tc  = 0;
      end else begin
        m_remaining = m_remaining - 1;
        m_tc        = (m_remaining == 0);
        if (m_remaining == 0) begin
`ifdef LOOP_CTR_AUTORELOAD_EN
          m_remaining = m_bound;
`else
          m_active = 0;
`endif
        end
      end
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic compare_model();
    check("data_out", data_out, m_remaining);
    check("zero", zero, (m_remaining == 0));
    check("busy", busy, m_active);
    check("tc", tc, m_tc);
    check("err", err, m_err);
  endtask

  task automatic cycle(input bit we, input int d, input bit dec);
    write_en = we;
    decre    = dec;
    data_in  = W'(d);
    @(posedge clk);
    model_step(we, d, dec);
    @(negedge clk);
    write_en = 1'b0;
    decre    = 1'b0;
    compare_model();
  endtask

  initial begin
    rst      = 1'b0;
    write_en = 1'b0;
    decre    = 1'b0;
    data_in  = '0;
    model_reset();
    @(negedge clk);
    phase = "reset";
    compare_model();
    check("reset_zero", zero, 1);
    rst = 1'b1;
    @(negedge clk);

    phase = "async_reset";
    cycle(1, 5, 0);
    check("loaded5", data_out, 5);
    rst = 1'b0;
    #1;
    model_reset();
    compare_model();
    check("rst_data", data_out, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    phase = "normal";
    cycle(1, 3, 0);
    check("load3", data_out, 3);
    cycle(0, 0, 1);
    check("step1", data_out, 2);
    cycle(0, 0, 1);
    check("step2_tc", tc, 0);
    cycle(0, 0, 1);
    check("term_tc", tc, 1);
`ifdef LOOP_CTR_AUTORELOAD_EN
    check("term_data", data_out, 3);
`else
    check("term_data", data_out, 0);
    check("term_busy", busy, 0);
`endif
    cycle(0, 0, 0);
    check("tc_drop", tc, 0);

    phase = "misuse";
    cycle(1, 0, 0);
    check("load0_busy", busy, 0);
    cycle(0, 0, 1);
    check("err_set", err, 1);
    check("hold0", data_out, 0);
    cycle(0, 0, 0);
    check("err_sticky", err, 1);
    cycle(1, 4, 0);
    check("err_clr", err, 0);

    phase = "collision";
    cycle(1, 3, 0);
    cycle(0, 0, 1);
    cycle(1, 7, 1);
    check("coll_data", data_out, 7);
    check("coll_tc", tc, 0);

    phase = "reload2";
    cycle(1, 2, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1);
`ifdef LOOP_CTR_AUTORELOAD_EN
      check("ar_zero", zero, 0);
      check("ar_tc", tc, (i % 2) == 1);
`endif
    end

    phase = "max";
    cycle(1, 'hFFFF, 0);
    cycle(0, 0, 1);
    check("max_dec", data_out, 'hFFFE);
    cycle(1, 1, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
`ifndef LOOP_CTR_AUTORELOAD_EN
    check("one_err", err, 1);
    check("one_data", data_out, 0);
`endif

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      int d;
      bit we;
      bit dec;
      we  = ($urandom_range(0, 5) == 0);
      dec = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0:       d = 0;
        1:       d = 'hFFFF;
        default: d = $urandom_range(1, 6);
      endcase
      cycle(we, d, dec);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        compare_model();
        @(negedge clk);
        rst = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
